// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud divider that
// transmitter and receiver must agree on.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 434;
  localparam int CNT_W             = 9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    ACCEPT  = 3'd4,
    WAIT_HI = 3'd5
  } rx_state_t;

  // The debug LED counter wraps modulo 4 by construction.
  function automatic logic [1:0] led_inc(input logic [1:0] led);
    return led + 2'd1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input. Resets high so an idle
// serial line is never mistaken for a start bit coming out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
    end
  end

  assign sync_out = sync_r;

endmodule

// File: rtl/uart_rx_char.sv
// 8N1 UART receiver: centre-samples each bit, holds the byte in a valid/ack
// register, and reports framing errors, overruns and a 2-bit byte counter.
module uart_rx_char
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [1:0] led
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  logic             rx_s;
  logic             ack_take_s;

  rx_state_t        state_r,     state_nxt;
  logic [CNT_W-1:0] cnt_r,       cnt_nxt;
  logic [2:0]       bit_idx_r,   bit_idx_nxt;
  logic [7:0]       shreg_r,     shreg_nxt;
  logic [7:0]       rx_data_r,   rx_data_nxt;
  logic             rx_valid_r,  rx_valid_nxt;
  logic             frame_err_r, frame_err_nxt;
  logic             overrun_r,   overrun_nxt;
  logic             busy_r,      busy_nxt;
  logic [1:0]       led_r,       led_nxt;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (rx),
    .sync_out (rx_s)
  );

  // An ack only counts while a byte is actually being held.
  assign ack_take_s = rx_ack & rx_valid_r;

  // Next-state, counters, shift register and output register updates.
  always_comb begin
    state_nxt     = state_r;
    cnt_nxt       = cnt_r + CNT_W'(1);
    bit_idx_nxt   = bit_idx_r;
    shreg_nxt     = shreg_r;
    rx_data_nxt   = rx_data_r;
    rx_valid_nxt  = rx_valid_r;
    frame_err_nxt = 1'b0;
    overrun_nxt   = overrun_r;
    led_nxt       = led_r;

    if (ack_take_s) begin
      rx_valid_nxt = 1'b0;
      overrun_nxt  = 1'b0;
    end else begin
      rx_valid_nxt = rx_valid_r;
      overrun_nxt  = overrun_r;
    end

    case (state_r)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end

      START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_nxt = '0;
          // A line that is high again at mid start bit was only a glitch.
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            bit_idx_nxt = 3'd0;
          end
        end else begin
          state_nxt = START;
        end
      end

      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt              = '0;
          shreg_nxt[bit_idx_r] = rx_s;
          if (bit_idx_r == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx_r + 3'd1;
          end
        end else begin
          state_nxt = DATA;
        end
      end

      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = ACCEPT;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = WAIT_HI;
          end
        end else begin
          state_nxt = STOP;
        end
      end

      ACCEPT: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
        // A same-cycle ack frees the holding register for the new byte.
        if (!rx_valid_r || ack_take_s) begin
          rx_data_nxt  = shreg_r;
          rx_valid_nxt = 1'b1;
          led_nxt      = led_inc(led_r);
        end else begin
          overrun_nxt = 1'b1;
        end
      end

      WAIT_HI: begin
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_HI;
        end
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      bit_idx_r   <= 3'd0;
      shreg_r     <= 8'd0;
      rx_data_r   <= 8'd0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
      led_r       <= 2'd0;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      bit_idx_r   <= bit_idx_nxt;
      shreg_r     <= shreg_nxt;
      rx_data_r   <= rx_data_nxt;
      rx_valid_r  <= rx_valid_nxt;
      frame_err_r <= frame_err_nxt;
      overrun_r   <= overrun_nxt;
      busy_r      <= busy_nxt;
      led_r       <= led_nxt;
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;
  assign led       = led_r;

endmodule
